b_perceptron_trainer: RTL and testbench

Resolution and learning end of the B-branch perceptron predictor. It receives the predicted B outcomes for each fetch bundle and queues them in order. When the execute stage reports the real outcomes, it retires them in order, trains the per-slot perceptron weights and repairs the global history. On a misprediction it issues the correct PC. It owns every piece of predictor state that the prediction path reads: global history, weights, pending-B count, retire counter and correct PC.

---
 rtl/b_pred_pkg.sv | 30 +++
 rtl/b_pending_queue.sv | 60 ++++++
 rtl/b_perceptron_trainer.sv | 208 ++++++++++++++++++++
 tb/tb_b_perceptron_trainer.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/b_pred_pkg.sv
// Shared definitions for the B-branch perceptron predictor.
//   - instruction type codes (NORMAL / B)
//   - history, row and weight geometry
//   - flat weight-bus index helper
//   - pending-branch queue entry type {pred, slot, ghr}
package b_pred_pkg;

    typedef enum logic {
        NORMAL = 1'b0,
        B      = 1'b1
    } instType_e;

    localparam int unsigned GHR_W  = 20;  // global history length
    localparam int unsigned HIST_N = 8;   // history bits feeding each row
    localparam int unsigned ROWS   = 4;   // one row per bundle slot
    localparam int unsigned W_W    = 8;   // weight width
    localparam int unsigned ROW_W  = (HIST_N + 1) * W_W;  // weights + bias

    // Bit offset of weight j (j == HIST_N is the bias) in row r of the flat bus.
    function automatic int unsigned wIdx(input int unsigned r, input int unsigned j);
        return r * ROW_W + j * W_W;
    endfunction

    typedef struct packed {
        logic             pred;  // predicted direction
        logic [1:0]       slot;  // row index
        logic [GHR_W-1:0] ghr;   // history before this entry's own shift
    } pendEntry_t;

endpackage

// File: rtl/b_pending_queue.sv
// Circular buffer of outstanding predicted B entries.
//   clk, rst   : clock, synchronous active-high reset
//   pushNum    : entries to write this cycle (0..4), taken from pushData[0..]
//   pushData   : up to four entries in bundle order
//   popEn      : retire the head entry
//   flush      : discard all entries (wins over push/pop)
//   head       : oldest entry
//   count      : current occupancy (0..DEPTH)
module b_pending_queue
    import b_pred_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [2:0]                 pushNum,
    input  pendEntry_t                 pushData [4],
    input  logic                       popEn,
    input  logic                       flush,
    output pendEntry_t                 head,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    pendEntry_t      mem [DEPTH];
    logic [PW-1:0]   wrPtr;
    logic [PW-1:0]   rdPtr;
    logic [CW-1:0]   cnt;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wrPtr <= '0;
            rdPtr <= '0;
            cnt   <= '0;
        end else begin
            if (popEn) begin
                rdPtr <= rdPtr + PW'(1);
            end
            // Pointer arithmetic truncates to PW bits, giving wrap modulo DEPTH.
            wrPtr <= wrPtr + PW'(pushNum);
            cnt   <= cnt + CW'(pushNum) - CW'(popEn);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && !flush) begin
            for (int unsigned k = 0; k < 4; k++) begin
                if (k < 32'(pushNum)) begin
                    mem[wrPtr + PW'(k)] <= pushData[k];
                end
            end
        end
    end

    assign head  = mem[rdPtr];
    assign count = cnt;

endmodule

// File: rtl/b_perceptron_trainer.sv
// Resolution / training end of the B-branch perceptron predictor.
// Queues predicted B outcomes per fetch bundle, retires them in order against
// execute results, trains the per-slot perceptron rows, repairs the global
// history and issues a redirect PC on a misprediction.
//   i_clk, i_rst              : clock, synchronous active-high reset
//   i_pushValid/i_passBNum_3/
//   i_predictGotJ/o_pushReady : bundle prediction enqueue handshake
//   i_resolveValid/Taken/Pc/
//   Target, o_resolveReady    : oldest-branch resolve handshake
//   o_globalHistoryRegister_20: speculative history, bit 0 newest
//   o_weights_288             : 4 rows x 9 signed 8-bit weights (j=8 bias)
//   o_correctPC_32            : redirect PC for one cycle, else 0
//   o_counter_3               : entries retired in the previous cycle
//   o_pendingB_8              : queue occupancy
//   o_underflow               : sticky resolve-on-empty flag
module b_perceptron_trainer
    import b_pred_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned THETA = 29,
    parameter int unsigned WMAX  = 127
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_pushValid,
    input  logic [2:0]   i_passBNum_3,
    input  logic         i_predictGotJ,
    output logic         o_pushReady,
    input  logic         i_resolveValid,
    input  logic         i_resolveTaken,
    input  logic [31:0]  i_resolvePc_32,
    input  logic [31:0]  i_resolveTarget_32,
    output logic         o_resolveReady,
    output logic [19:0]  o_globalHistoryRegister_20,
    output logic [287:0] o_weights_288,
    output logic [31:0]  o_correctPC_32,
    output logic [2:0]   o_counter_3,
    output logic [7:0]   o_pendingB_8,
    output logic         o_underflow
);

    typedef enum logic {
        RUN     = 1'b0,
        RECOVER = 1'b1
    } state_e;

    localparam logic signed [W_W-1:0] WPOS = W_W'(WMAX);
    localparam logic signed [W_W-1:0] WNEG = -WPOS;

    function automatic logic signed [W_W-1:0] satStep(input logic signed [W_W-1:0] w,
                                                      input logic up);
        if (up) begin
            return (w >= WPOS) ? WPOS : w + 8'sd1;
        end
        return (w <= WNEG) ? WNEG : w - 8'sd1;
    endfunction

    state_e                 state;
    state_e                 nextState;
    logic                   runState;

    logic [GHR_W-1:0]       ghr;
    logic signed [W_W-1:0]  weights [ROWS][HIST_N+1];
    logic [31:0]            correctPC;
    logic [2:0]             counter;
    logic                   underflow;

    logic [2:0]             effN;
    logic                   pushFire;
    logic                   doPush;
    logic                   resolveFire;
    logic                   retire;
    logic                   mispredict;
    logic                   train;
    logic signed [11:0]     sum;
    logic [11:0]            absSum;
    logic [GHR_W-1:0]       pushGhr;

    pendEntry_t             pushData [4];
    pendEntry_t             head;
    logic [$clog2(DEPTH):0] count;

    // Counts above 4 (incl. the error code 7) are accepted but enqueue nothing.
    assign effN        = (i_passBNum_3 <= 3'd4) ? i_passBNum_3 : 3'd0;
    assign runState    = (state == RUN);
    assign pushFire    = i_pushValid && o_pushReady;
    assign resolveFire = i_resolveValid && o_resolveReady;
    assign retire      = resolveFire && (count != '0);
    assign mispredict  = retire && (i_resolveTaken != head.pred);
    // A same-cycle flush wins over the push.
    assign doPush      = pushFire && (effN != 3'd0) && !mispredict;

    // FSM next state and handshake readies
    always_comb begin
        nextState      = state;
        o_resolveReady = 1'b0;
        o_pushReady    = 1'b0;
        case (state)
            RUN: begin
                o_resolveReady = 1'b1;
                o_pushReady    = (32'(count) + 32'(effN)) <= DEPTH;
                if (mispredict) begin
                    nextState = RECOVER;
                end
            end
            RECOVER: nextState = RUN;
            default: nextState = RUN;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= RUN;
        end else begin
            state <= nextState;
        end
    end

    // Bundle entries: only the last one can carry a taken prediction, so each
    // snapshot is the current history shifted by the zeros inserted before it.
    always_comb begin
        for (int unsigned k = 0; k < 4; k++) begin
            pushData[k].pred = ((k + 1) == 32'(effN)) && i_predictGotJ;
            pushData[k].slot = 2'(k);
            pushData[k].ghr  = ghr << k;
        end
        pushGhr = (ghr << effN) | {{(GHR_W-1){1'b0}}, i_predictGotJ};
    end

    // Perceptron output of the head entry's row, from current weights.
    always_comb begin
        sum = {{4{weights[head.slot][HIST_N][W_W-1]}}, weights[head.slot][HIST_N]};
        for (int unsigned j = 0; j < HIST_N; j++) begin
            if (j >= 32'(head.slot) && head.ghr[5'(j)]) begin
                sum = sum + {{4{weights[head.slot][4'(j)][W_W-1]}}, weights[head.slot][4'(j)]};
            end
        end
        absSum = sum[11] ? 12'(-sum) : 12'(sum);
        train  = (i_resolveTaken != head.pred) || (absSum <= 12'(THETA));
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int unsigned r = 0; r < ROWS; r++) begin
                for (int unsigned j = 0; j <= HIST_N; j++) begin
                    weights[r][j] <= '0;
                end
            end
        end else if (retire && train) begin
            weights[head.slot][HIST_N] <= satStep(weights[head.slot][HIST_N], i_resolveTaken);
            for (int unsigned j = 0; j < HIST_N; j++) begin
                if (j >= 32'(head.slot) && head.ghr[5'(j)]) begin
                    weights[head.slot][4'(j)] <= satStep(weights[head.slot][4'(j)], i_resolveTaken);
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            ghr       <= '0;
            correctPC <= '0;
            counter   <= '0;
            underflow <= 1'b0;
        end else begin
            if (mispredict) begin
                ghr <= {head.ghr[GHR_W-2:0], i_resolveTaken};
            end else if (doPush) begin
                ghr <= pushGhr;
            end
            if (mispredict) begin
                correctPC <= i_resolveTaken ? i_resolveTarget_32 : i_resolvePc_32 + 32'd4;
            end else begin
                correctPC <= '0;
            end
            counter <= {2'b00, retire};
            if (resolveFire && (count == '0)) begin
                underflow <= 1'b1;
            end
        end
    end

    b_pending_queue #(
        .DEPTH (DEPTH)
    ) uQueue (
        .clk      (i_clk),
        .rst      (i_rst),
        .pushNum  (doPush ? effN : 3'd0),
        .pushData (pushData),
        .popEn    (retire && !mispredict),
        .flush    (mispredict),
        .head     (head),
        .count    (count)
    );

    for (genvar r = 0; r < ROWS; r++) begin : gRow
        for (genvar j = 0; j <= HIST_N; j++) begin : gCol
            assign o_weights_288[wIdx(r, j) +: W_W] = weights[r][j];
        end
    end

    assign o_globalHistoryRegister_20 = ghr;
    assign o_correctPC_32             = correctPC;
    assign o_counter_3                = counter;
    assign o_pendingB_8               = 8'(count);
    assign o_underflow                = underflow;

endmodule

// File: tb/tb_b_perceptron_trainer.sv
// Directed self-checking bench for b_perceptron_trainer.
module tb_b_perceptron_trainer;

    logic         clk = 1'b0;
    logic         rst;
    logic         pushValid;
    logic [2:0]   passBNum;
    logic         predictGotJ;
    logic         pushReady;
    logic         resolveValid;
    logic         resolveTaken;
    logic [31:0]  resolvePc;
    logic [31:0]  resolveTarget;
    logic         resolveReady;
    logic [19:0]  ghr;
    logic [287:0] weights;
    logic [31:0]  correctPC;
    logic [2:0]   counter;
    logic [7:0]   pendingB;
    logic         underflow;

    int passCnt  = 0;
    int checkCnt = 0;

    always #5 clk = ~clk;

    b_perceptron_trainer #(
        .DEPTH (8),
        .THETA (29),
        .WMAX  (127)
    ) dut (
        .i_clk                      (clk),
        .i_rst                      (rst),
        .i_pushValid                (pushValid),
        .i_passBNum_3               (passBNum),
        .i_predictGotJ              (predictGotJ),
        .o_pushReady                (pushReady),
        .i_resolveValid             (resolveValid),
        .i_resolveTaken             (resolveTaken),
        .i_resolvePc_32             (resolvePc),
        .i_resolveTarget_32         (resolveTarget),
        .o_resolveReady             (resolveReady),
        .o_globalHistoryRegister_20 (ghr),
        .o_weights_288              (weights),
        .o_correctPC_32             (correctPC),
        .o_counter_3                (counter),
        .o_pendingB_8               (pendingB),
        .o_underflow                (underflow)
    );

    function automatic logic [7:0] wt(input int r, input int j);
        return weights[r*72 + j*8 +: 8];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCnt++;
        assert (obs === exp) passCnt++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        pushValid    = 1'b0;
        resolveValid = 1'b0;
    endtask

    task automatic setPush(input logic [2:0] n, input logic j);
        pushValid   = 1'b1;
        passBNum    = n;
        predictGotJ = j;
    endtask

    task automatic setResolve(input logic t, input logic [31:0] pc, input logic [31:0] tgt);
        resolveValid  = 1'b1;
        resolveTaken  = t;
        resolvePc     = pc;
        resolveTarget = tgt;
    endtask

    initial begin
        rst = 1'b1;
        pushValid = 1'b0; passBNum = 3'd0; predictGotJ = 1'b0;
        resolveValid = 1'b0; resolveTaken = 1'b0; resolvePc = '0; resolveTarget = '0;
        tick(); tick();
        rst = 1'b0;

        // Reset state
        chk("rst_pending", 32'(pendingB), 32'd0);
        chk("rst_ghr", 32'(ghr), 32'd0);
        chk("rst_cpc", correctPC, 32'd0);
        chk("rst_counter", 32'(counter), 32'd0);
        chk("rst_underflow", 32'(underflow), 32'd0);
        chk("rst_pushReady", 32'(pushReady), 32'd1);
        chk("rst_resolveReady", 32'(resolveReady), 32'd1);
        chk("rst_w08", 32'(wt(0, 8)), 32'd0);

        // Push 3 entries, last predicted taken
        setPush(3'd3, 1'b1);
        tick(); idle();
        chk("push3_pending", 32'(pendingB), 32'd3);
        chk("push3_ghr", 32'(ghr), 32'h1);

        // Correct not-taken on slot 0: sum 0 trains bias down
        setResolve(1'b0, 32'h200, 32'h300);
        tick(); idle();
        chk("res0_counter", 32'(counter), 32'd1);
        chk("res0_cpc", correctPC, 32'd0);
        chk("res0_bias", 32'(wt(0, 8)), 32'h0FF);
        chk("res0_pending", 32'(pendingB), 32'd2);
        chk("res0_ghr", 32'(ghr), 32'h1);
        tick();
        chk("res0_counter_next", 32'(counter), 32'd0);

        // Slot 1 predicted not-taken, actually taken
        setResolve(1'b1, 32'h204, 32'h1000);
        tick(); idle();
        chk("mis_cpc", correctPC, 32'h1000);
        chk("mis_pending", 32'(pendingB), 32'd0);
        chk("mis_ghr", 32'(ghr), 32'h1);
        chk("mis_pushReady", 32'(pushReady), 32'd0);
        chk("mis_resolveReady", 32'(resolveReady), 32'd0);
        chk("mis_w18", 32'(wt(1, 8)), 32'd1);
        setPush(3'd1, 1'b0);  // offered during RECOVER, must be dropped
        tick(); idle();
        chk("rec_cpc", correctPC, 32'd0);
        chk("rec_pending", 32'(pendingB), 32'd0);
        chk("rec_ghr", 32'(ghr), 32'h1);
        chk("rec_resolveReady", 32'(resolveReady), 32'd1);

        // Fill to 8
        setPush(3'd4, 1'b0);
        tick();
        tick(); idle();
        chk("full_pending", 32'(pendingB), 32'd8);
        chk("full_ghr", 32'(ghr), 32'h100);
        setPush(3'd2, 1'b0);
        chk("full_push2_ready", 32'(pushReady), 32'd0);
        tick(); idle();
        chk("full_push2_pending", 32'(pendingB), 32'd8);

        // Full: push 1 refused even with a same-cycle pop
        setPush(3'd1, 1'b1);
        setResolve(1'b0, 32'h300, 32'h400);
        chk("full_push1_ready", 32'(pushReady), 32'd0);
        tick(); idle();
        chk("full_pop_pending", 32'(pendingB), 32'd7);
        chk("full_pop_ghr", 32'(ghr), 32'h100);
        chk("full_pop_w08", 32'(wt(0, 8)), 32'h0FE);
        chk("full_pop_w00", 32'(wt(0, 0)), 32'h0FF);

        // Count 7: push 1 plus correct pop keeps the count
        setPush(3'd1, 1'b1);
        setResolve(1'b0, 32'h304, 32'h400);
        chk("both_push_ready", 32'(pushReady), 32'd1);
        tick(); idle();
        chk("both_pending", 32'(pendingB), 32'd7);
        chk("both_ghr", 32'(ghr), 32'h201);
        chk("both_w18", 32'(wt(1, 8)), 32'd0);
        chk("both_w11", 32'(wt(1, 1)), 32'h0FF);

        // Mispredict on slot 2 flushes the queue
        setResolve(1'b1, 32'h308, 32'h2000);
        tick(); idle();
        chk("flush_cpc", correctPC, 32'h2000);
        chk("flush_pending", 32'(pendingB), 32'd0);
        chk("flush_ghr", 32'(ghr), 32'h9);
        chk("flush_w28", 32'(wt(2, 8)), 32'd1);
        chk("flush_w22", 32'(wt(2, 2)), 32'd1);
        tick();

        // 200 taken-mispredicts on the row 0 bias
        for (int i = 0; i < 200; i++) begin
            setPush(3'd1, 1'b0);
            tick(); idle();
            setResolve(1'b1, 32'h500, 32'h3000);
            tick(); idle();
            tick();
        end
        chk("sat_w08", 32'(wt(0, 8)), 32'd127);
        chk("sat_w00", 32'(wt(0, 0)), 32'd127);
        chk("sat_w07", 32'(wt(0, 7)), 32'd127);
        chk("sat_ghr", 32'(ghr), 32'hFFFFF);
        chk("sat_pending", 32'(pendingB), 32'd0);

        // Resolve on empty queue
        setResolve(1'b0, 32'h600, 32'h700);
        tick(); idle();
        chk("uf_flag", 32'(underflow), 32'd1);
        chk("uf_pending", 32'(pendingB), 32'd0);
        chk("uf_counter", 32'(counter), 32'd0);
        chk("uf_ghr", 32'(ghr), 32'hFFFFF);
        chk("uf_cpc", correctPC, 32'd0);

        // Error code 7 is accepted and ignored
        setPush(3'd7, 1'b1);
        chk("n7_ready", 32'(pushReady), 32'd1);
        tick(); idle();
        chk("n7_pending", 32'(pendingB), 32'd0);
        chk("n7_ghr", 32'(ghr), 32'hFFFFF);

        // Two entries: slot0 pred0, slot1 pred1
        setPush(3'd2, 1'b1);
        tick(); idle();
        chk("p2_pending", 32'(pendingB), 32'd2);
        chk("p2_ghr", 32'(ghr), 32'hFFFFD);
        // Correct with |sum| far above threshold: no training
        setResolve(1'b0, 32'h700, 32'h800);
        tick(); idle();
        chk("theta_w08", 32'(wt(0, 8)), 32'd127);
        chk("theta_counter", 32'(counter), 32'd1);
        // Correct taken on slot 1 with sum -1: trains up
        setResolve(1'b1, 32'h704, 32'h800);
        tick(); idle();
        chk("s1_w18", 32'(wt(1, 8)), 32'd1);
        chk("s1_w11", 32'(wt(1, 1)), 32'd0);
        chk("s1_cpc", correctPC, 32'd0);
        chk("s1_ghr", 32'(ghr), 32'hFFFFD);
        chk("s1_underflow_held", 32'(underflow), 32'd1);

        // Not-taken target path: pc + 4 redirect, then reset mid-RECOVER
        setPush(3'd1, 1'b1);
        tick(); idle();
        setResolve(1'b0, 32'h4000, 32'h9000);
        tick(); idle();
        chk("nt_cpc", correctPC, 32'h4004);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst2_pushReady", 32'(pushReady), 32'd1);
        chk("rst2_resolveReady", 32'(resolveReady), 32'd1);
        chk("rst2_cpc", correctPC, 32'd0);
        chk("rst2_underflow", 32'(underflow), 32'd0);
        chk("rst2_pending", 32'(pendingB), 32'd0);
        chk("rst2_ghr", 32'(ghr), 32'd0);
        chk("rst2_w08", 32'(wt(0, 8)), 32'd0);

        $display("%0d/%0d checks passed", passCnt, checkCnt);
        $finish;
    end

endmodule
